ad7352_rx: RTL and testbench

AD7352_RX -- requirements
Module: ad7352_rx

---
 rtl/ad7352_rx.sv | 90 +++++++++
 tb/tb_ad7352_rx.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/ad7352_rx.sv
// ad7352_rx: AD7352 dual-ADC serial receiver (4 lanes, 12-bit, back-to-back frames)
// Define ADC_TRIP_EN to add the iout overcurrent trip with trip_clr; otherwise trip is tied low.
module ad7352_rx #(
  parameter int          CS_HIGH    = 2,
  parameter logic [11:0] TRIP_LEVEL = 12'd2560
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  output logic        ad_cs,
  input  logic [1:0]  ad_sdata_a,
  input  logic [1:0]  ad_sdata_b,
  output logic [11:0] vcap,
  output logic [11:0] vout,
  output logic [11:0] icap,
  output logic [11:0] iout,
  output logic        sample_valid,
`ifdef ADC_TRIP_EN
  input  logic        trip_clr,
`endif
  output logic        trip
);
  typedef enum logic {IDLE, CONV} state_t;
  localparam logic [3:0] CS_N = 4'(CS_HIGH);
  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              cs_q, pend_q, pend_d, valid_q, shift_en;
  logic [3:0]        lane;
  logic [3:0][11:0]  sh_q, out_q;
  // lane order: 3=vcap, 2=icap, 1=vout, 0=iout
  assign lane     = {ad_sdata_b, ad_sdata_a};
  assign shift_en = (state_q == CONV) && (cnt_q != 4'd0);
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = 1'b0;
    if (state_q == IDLE) begin
      if (cnt_q >= CS_N && enable) begin
        state_d = CONV;
        cnt_d   = 4'd0;
      end else begin
        cnt_d = (cnt_q == 4'hf) ? cnt_q : cnt_q + 4'd1;
      end
    end else if (cnt_q == 4'd12) begin
      state_d = IDLE;
      cnt_d   = 4'd0;
      pend_d  = 1'b1;
    end else begin
      cnt_d = cnt_q + 4'd1;
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      cs_q    <= 1'b1;
      pend_q  <= 1'b0;
      valid_q <= 1'b0;
      sh_q    <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cs_q    <= (state_d == IDLE);
      pend_q  <= pend_d;
      valid_q <= pend_q;
      if (pend_q) out_q <= sh_q;
      if (shift_en)
        for (int i = 0; i < 4; i++) sh_q[i] <= {sh_q[i][10:0], lane[i]};
    end
  end
  assign ad_cs        = cs_q;
  assign sample_valid = valid_q;
  assign vcap         = out_q[3];
  assign icap         = out_q[2];
  assign vout         = out_q[1];
  assign iout         = out_q[0];
`ifdef ADC_TRIP_EN
  logic trip_q, trip_d;
  // a new trip condition outranks a simultaneous clear
  always_comb trip_d = (pend_q && sh_q[0] > TRIP_LEVEL) ? 1'b1 : trip_clr ? 1'b0 : trip_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) trip_q <= 1'b0;
    else trip_q <= trip_d;
  end
  assign trip = trip_q;
`else
  assign trip = 1'b0;
`endif
endmodule

// File: tb/tb_ad7352_rx.sv
// tb_ad7352_rx: directed bench for ad7352_rx with a behavioural AD7352 lane model.
// Trip checks are compiled only when ADC_TRIP_EN is defined.
module tb_ad7352_rx;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic        ad_cs;
  logic [1:0]  ad_sdata_a = 2'bxx;
  logic [1:0]  ad_sdata_b = 2'bxx;
  logic [11:0] vcap, vout, icap, iout;
  logic        sample_valid, trip;
  logic        trip_clr = 1'b0;
  logic [11:0] w_vcap = 12'h0, w_icap = 12'h0, w_vout = 12'h0, w_iout = 12'h0;
  int          checks = 0, errors = 0, k = 0, n = 0, bad = 0;

  ad7352_rx dut (
    .clk(clk), .reset(reset), .enable(enable), .ad_cs(ad_cs),
    .ad_sdata_a(ad_sdata_a), .ad_sdata_b(ad_sdata_b),
    .vcap(vcap), .vout(vout), .icap(icap), .iout(iout),
    .sample_valid(sample_valid),
`ifdef ADC_TRIP_EN
    .trip_clr(trip_clr),
`endif
    .trip(trip)
  );

  always #5 clk = ~clk;

  // ADC: one leading zero after CS falls, then bits 11..0 on falling edges; lanes X while CS is high
  always @(negedge clk) begin
    if (ad_cs) begin
      k = 0;
      ad_sdata_a = 2'bxx;
      ad_sdata_b = 2'bxx;
    end else begin
      if (k == 0 || k > 12) begin
        ad_sdata_a = 2'b00;
        ad_sdata_b = 2'b00;
      end else begin
        ad_sdata_b = {w_vcap[12-k], w_icap[12-k]};
        ad_sdata_a = {w_vout[12-k], w_iout[12-k]};
      end
      k = k + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_valid(output int cnt);
    cnt = 0;
    do begin
      @(posedge clk); #1;
      cnt++;
    end while (!sample_valid && cnt < 64);
  endtask

  task automatic set_words(input logic [11:0] vc, input logic [11:0] ic, input logic [11:0] vo, input logic [11:0] io);
    w_vcap = vc; w_icap = ic; w_vout = vo; w_iout = io;
  endtask

  initial begin
    set_words(12'hA00, 12'h200, 12'hA00, 12'h200);
    enable = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cs", ad_cs, 1);
    chk("rst_valid", sample_valid, 0);
    chk("rst_out", {vcap, iout}, 0);
    chk("rst_trip", trip, 0);
    @(negedge clk) reset = 1'b0;
    wait_valid(n);
    chk("first_valid_edge", n, 17);
    chk("op_vcap", vcap, 12'hA00);
    chk("op_iout", iout, 12'h200);
    chk("op_vout", vout, 12'hA00);
    chk("op_icap", icap, 12'h200);
    set_words(12'hAAA, 12'h555, 12'hFFF, 12'h000);
    @(posedge clk); #1;
    chk("valid_one_cycle", sample_valid, 0);
    repeat (7) @(posedge clk);
    #1;
    chk("hold_mid_frame", {vcap, vout}, {12'hA00, 12'hA00});
    chk("no_partial_valid", sample_valid, 0);
    wait_valid(n);
    chk("period", n + 8, 16);
    chk("pat_vcap", vcap, 12'hAAA);
    chk("pat_icap", icap, 12'h555);
    chk("pat_vout", vout, 12'hFFF);
    chk("pat_iout", iout, 12'h000);
    chk("no_x", {31'd0, $isunknown({vcap, icap, vout, iout, sample_valid, trip})}, 0);
    set_words(12'h123, 12'h456, 12'h789, 12'h0AB);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (ad_cs && n < 20);
    chk("cs_low_seen", ad_cs, 0);
    repeat (5) @(posedge clk);
    #1;
    enable = 1'b0;
    wait_valid(n);
    chk("en_drop_valid", sample_valid, 1);
    chk("en_drop_data", {vcap, iout}, {12'h123, 12'h0AB});
    chk("en_drop_icap_vout", {icap, vout}, {12'h456, 12'h789});
    bad = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (!ad_cs || sample_valid) bad++;
    end
    chk("idle_after_drop", bad, 0);
    chk("hold_after_drop", vcap, 12'h123);
    enable = 1'b1;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (ad_cs && n < 10);
    chk("en_restart_le3", {31'd0, n <= 3}, 1);
    repeat (8) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    chk("abort_cs", ad_cs, 1);
    chk("abort_out", {vcap, icap, vout, iout}, 0);
    chk("abort_valid", sample_valid, 0);
    set_words(12'hFED, 12'h001, 12'h800, 12'h7FF);
    @(posedge clk); #1;
    chk("abort_valid_hold", sample_valid, 0);
    @(negedge clk) reset = 1'b0;
    wait_valid(n);
    chk("post_abort_edge", n, 17);
    chk("post_abort_vc_ic", {vcap, icap}, {12'hFED, 12'h001});
    chk("post_abort_vo_io", {vout, iout}, {12'h800, 12'h7FF});
    chk("post_abort_trip", trip, 0);
`ifdef ADC_TRIP_EN
    set_words(12'hA00, 12'h200, 12'hA00, 12'hA01);
    wait_valid(n);
    chk("trip_iout", iout, 12'hA01);
    chk("trip_set", trip, 1);
    trip_clr = 1'b1;
    set_words(12'hA00, 12'h200, 12'hA00, 12'hA00);
    @(posedge clk); #1;
    trip_clr = 1'b0;
    chk("trip_clr", trip, 0);
    wait_valid(n);
    chk("trip_eq_level_iout", iout, 12'hA00);
    chk("trip_eq_level", trip, 0);
    set_words(12'hA00, 12'h200, 12'hA00, 12'hA01);
    trip_clr = 1'b1;
    wait_valid(n);
    chk("trip_set_wins", trip, 1);
    @(posedge clk); #1;
    trip_clr = 1'b0;
    chk("trip_clr_after", trip, 0);
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
